// File: rtl/alu_exec_pkg.sv
// Shared ALUop encodings for the execute-stage ALU (values match the CS150 ALUop.vh table).
package alu_exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADDU = 4'd0,
    ALU_SUBU = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_LUI  = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_SRL  = 4'd10,
    ALU_NOR  = 4'd11
  } alu_op_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_serial_shifter.sv
// One-bit-per-cycle shifter: working register plus a count of shifts still owed.
module alu_serial_shifter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic               left_i,
  input  logic               arith_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  logic [SHAMT_W-1:0] amount_i,
  output logic               done_o,
  output logic [WIDTH-1:0]   result_o
);

  logic [WIDTH-1:0]   work_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               left_q;
  logic               arith_q;

  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] v,
                                             input logic l, input logic ar);
    return l ? {v[WIDTH-2:0], 1'b0} : {ar & v[WIDTH-1], v[WIDTH-1:1]};
  endfunction

  // The first shift is taken on the load edge; the last one is taken combinationally
  // into result_o, so cnt_q==1 marks the completing cycle.
  assign done_o   = (cnt_q == SHAMT_W'(1));
  assign result_o = step1(work_q, left_q, arith_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q  <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      work_q  <= step1(operand_i, left_i, arith_i);
      cnt_q   <= amount_i - SHAMT_W'(1);
      left_q  <= left_i;
      arith_q <= arith_i;
    end else if (cnt_q != '0) begin
      work_q <= step1(work_q, left_q, arith_q);
      cnt_q  <= cnt_q - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with registered valid/ready result. Define ALU_BARREL_SHIFT_EN to
// replace the serial shifter with a single-cycle barrel shifter.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               illegal,
  output logic               busy
);

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             illegal_q, illegal_d;
  logic             accept;
  logic             op_shift;
  logic [WIDTH-1:0] op_res;
  logic             op_illegal;
`ifndef ALU_BARREL_SHIFT_EN
  logic             sh_load;
  logic             sh_done;
  logic [WIDTH-1:0] sh_result;
`endif

  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready) && !flush;
  assign accept    = in_valid && in_ready;
  assign op_shift  = is_shift_op(alu_op);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign illegal   = illegal_q;
  assign busy      = (state_q == S_SHIFT);

  always_comb begin
    op_res     = '0;
    op_illegal = 1'b0;
    case (alu_op)
      ALU_ADDU: op_res = a + b;
      ALU_SUBU: op_res = a - b;
      ALU_AND:  op_res = a & b;
      ALU_OR:   op_res = a | b;
      ALU_XOR:  op_res = a ^ b;
      ALU_NOR:  op_res = ~(a | b);
      ALU_SLT:  op_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: op_res = {{(WIDTH-1){1'b0}}, a < b};
      ALU_LUI:  op_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SLL:  op_res = b << shamt;
      ALU_SRL:  op_res = b >> shamt;
      ALU_SRA:  op_res = $signed(b) >>> shamt;
`else
      // Only shamt 0/1 finish on the accept edge; longer shifts go through the shifter.
      ALU_SLL:  op_res = (shamt == '0) ? b : {b[WIDTH-2:0], 1'b0};
      ALU_SRL:  op_res = (shamt == '0) ? b : {1'b0, b[WIDTH-1:1]};
      ALU_SRA:  op_res = (shamt == '0) ? b : {b[WIDTH-1], b[WIDTH-1:1]};
`endif
      default:  op_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    illegal_d   = illegal_q;
`ifndef ALU_BARREL_SHIFT_EN
    sh_load     = 1'b0;
`endif
    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end
`ifndef ALU_BARREL_SHIFT_EN
    else if (state_q == S_SHIFT) begin
      if (sh_done) begin
        result_d    = sh_result;
        illegal_d   = 1'b0;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
    end
`endif
    else if (accept) begin
`ifndef ALU_BARREL_SHIFT_EN
      if (op_shift && (shamt > SHAMT_W'(1))) begin
        sh_load = 1'b1;
        state_d = S_SHIFT;
      end else
`endif
      begin
        result_d    = op_res;
        illegal_d   = op_illegal;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      illegal_q   <= illegal_d;
    end
  end

`ifndef ALU_BARREL_SHIFT_EN
  alu_serial_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (flush),
    .load_i    (sh_load),
    .left_i    (alu_op == ALU_SLL),
    .arith_i   (alu_op == ALU_SRA),
    .operand_i (b),
    .amount_i  (shamt),
    .done_o    (sh_done),
    .result_o  (sh_result)
  );
`else
  logic unused_op_shift;
  assign unused_op_shift = op_shift;
`endif

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute-stage ALU for the CS150 MIPS datapath. It consumes the 4-bit ALUop produced by the ALU decoder, plus operands A and B and a shift amount.
- Returns a registered result over a valid/ready handshake.
- Shifts run on an area-saving serial shifter, one bit per cycle. All other ops complete in one cycle.
- Sits between operand select (register file / immediate muxing) and the MEM/WB stage.

Parameters:
- WIDTH, 32, datapath width in bits; LUI places B[WIDTH/2-1:0] in the upper half.
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort of in-flight op and output register
- in_valid  in  1  upstream presents an op
- in_ready  out  1  block can accept an op this cycle
- alu_op  in  4  ALUop encoding (constants from ALUop.vh)
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt or immediate)
- shamt  in  SHAMT_W  shift amount (constant or rs[4:0], chosen upstream)
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  downstream consumes result
- result  out  WIDTH  registered result
- illegal  out  1  result came from an undefined ALUop
- busy  out  1  serial shift in progress

Behaviour:
- Reset (rst_n low, async):
  - State goes to IDLE.
  - out_valid=0, result=0, illegal=0, busy=0.
  - Any in-flight shift is discarded.
  - in_ready reads 1 in the reset state.
- States:
  - IDLE: accepts ops.
  - SHIFT: a serial shift is in progress.
- Acceptance:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - An op is accepted on an edge where in_valid && in_ready.
- Non-shift ops (ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, LUI):
  - Result loads on the accept edge.
  - out_valid=1 the next cycle, so latency is 1.
  - Throughput is 1/cycle when out_ready is held high.
- Arithmetic rules:
  - ADDU/SUBU wrap modulo 2^WIDTH; no overflow detection.
  - SLT is a signed compare, SLTU an unsigned compare; the result is zero-extended 0/1.
  - LUI = {b[WIDTH/2-1:0], zeros}.
- Shift ops (SLL, SRL, SRA):
  - B is shifted by shamt. SRA fills with b[WIDTH-1]; SLL/SRL fill with 0.
  - shamt=0: result=b, latency 1.
  - shamt=n>=1: the first bit shift happens on the accept edge, then one bit per cycle in SHIFT.
  - out_valid rises n cycles after the accept cycle; state returns to IDLE on that same edge.
  - busy=1 exactly while state==SHIFT; in_ready=0 throughout.
- Output hold:
  - While out_valid && !out_ready, result and illegal are stable and no new op is accepted.
  - out_valid clears on the consume edge unless a new single-cycle result loads on that same edge.
- Undefined ALUop (any encoding not in ALUop.vh, including X in simulation):
  - Handled as a latency-1 op with result=0 and illegal=1.
  - illegal is 0 for every defined op.
- flush:
  - State goes to IDLE; out_valid=0 and busy=0 on the next edge.
  - Ops presented in the same cycle as flush are not accepted (in_ready is masked by flush).
  - flush has priority over out_ready.

Optional Feature:
- Macro: ALU_BARREL_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter and complete with latency 1 like every other op. SHIFT state is never entered and busy is tied 0.
- Undefined: serial shifter as specified above.
- The handshake is identical in both builds.

Decomposition:
- ALUop encodings stay in the shared ALUop.vh header. No new constants are added there.
- State encoding (IDLE/SHIFT) is a localparam inside the block.
- One natural sub-module: alu_serial_shifter, holding the working register, down-counter and direction/fill control. It is omitted when ALU_BARREL_SHIFT_EN is defined.

Test Plan:
- ADDU a=0xFFFFFFFF b=0x00000001 -> result 0x00000000, out_valid one cycle after accept, illegal=0.
- SLT a=0xFFFFFFFF b=0x00000001 -> result 1. SLTU with the same operands -> result 0. LUI b=0x00001234 -> result 0x12340000.
- SRA b=0x80000000 shamt=4 -> result 0xF8000000 with out_valid 4 cycles after accept. busy=1 and in_ready=0 during cycles 1-3. Repeat with ALU_BARREL_SHIFT_EN -> latency 1, busy never 1.
- Ten back-to-back ORs with out_ready=1 -> ten results on consecutive cycles. Drop out_ready for 3 cycles mid-stream -> result held stable, in_ready=0, no op lost or duplicated.
- SLL shamt=31 b=0x1, then rst_n low mid-shift -> out_valid=0, result=0, busy=0 immediately. A following ADDU 2+3 -> result 5. Repeat with flush instead of reset -> same outcome one edge later.
- Undefined ALUop encoding with a=b=0xFFFFFFFF -> result 0x00000000, illegal=1, latency 1. The next defined op returns illegal=0.
